// File: rtl/serializer_arbiter_if.sv
// Request bus between the per-lane packet sources and serializer_arbiter.
//   req_valid  source -> arbiter  per-channel word available
//   req_data   source -> arbiter  channel i word at [i*DATA_W +: DATA_W]
//   req_ready  arbiter -> source  one-hot grant; a word moves when valid & ready
// master: the packet sources side. slave: the arbiter side.
interface serializer_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 10
);

  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic [NUM_CH-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/serializer_arbiter.sv
// Round-robin arbiter and frame sequencer that shares one DATA_W-bit MSB-first
// serializer among NUM_CH requesters. One word is accepted per grant, handed to
// the serializer with a single-cycle load, and no further grant is made until
// the serializer has shifted out the last bit (plus GAP_CYCLES idle cycles).
//
// Ports
//   clk             rising-edge clock, shared with the serializer
//   reset           asynchronous, active-high; also resets the serializer
//   i_enable        1 = new grants allowed; 0 = finish current frame only
//   io_req          request bus (slave side): req_valid / req_data / req_ready
//   o_ser_load      registered load strobe to the serializer
//   o_ser_data      registered parallel word to the serializer
//   o_frame_active  high while in LOAD and SHIFT
//   o_frame_ch      channel that owns the current or most recent frame
//   o_frame_done    one-cycle pulse, first cycle after the last SHIFT cycle
//
// Timing for one frame (T0 = grant cycle):
//   T0        req_ready[g] high (combinational), word captured at the edge
//   T1        LOAD: o_ser_load high, the serializer samples at the end of T1
//   T2..T11   SHIFT: MSB on serial_out at T2, LSB at T(DATA_W+1)
//   T12       o_frame_done high; next grant possible here when GAP_CYCLES == 0
module serializer_arbiter #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned GAP_CYCLES = 0,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enable,
  serializer_arbiter_if.slave  io_req,
  output logic                 o_ser_load,
  output logic [DATA_W-1:0]    o_ser_data,
  output logic                 o_frame_active,
  output logic [CH_W-1:0]      o_frame_ch,
  output logic                 o_frame_done
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned GAP_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StGap
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              r_state;
  logic [CH_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic                r_ser_load;
  logic [DATA_W-1:0]   r_ser_data;
  logic                r_frame_active;
  logic [CH_W-1:0]     r_frame_ch;
  logic                r_frame_done;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid channel scanning rr_ptr, rr_ptr+1, ...
  // ---------------------------------------------------------------------------
  logic                w_found;
  logic [CH_W-1:0]     w_gnt_idx;
  logic [CH_W-1:0]     w_cand;
  logic                w_grant;
  logic [CH_W-1:0]     w_next_ptr;
  logic [DATA_W-1:0]   w_gnt_data;
  logic [NUM_CH-1:0]   w_ready;

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_cand = CH_W'((32'(r_rr_ptr) + i) % NUM_CH);
      if (!w_found && io_req.req_valid[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  // Grants only happen from IDLE; reset is folded in so req_ready is already
  // low while reset is asserted, matching every other output.
  assign w_grant = (r_state == StIdle) && i_enable && w_found && !reset;

  assign w_next_ptr = (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : (w_gnt_idx + CH_W'(1));

  assign w_gnt_data = io_req.req_data[int'(w_gnt_idx) * int'(DATA_W) +: DATA_W];

  always_comb begin
    w_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_ready[i] = w_grant && (w_gnt_idx == CH_W'(i));
    end
  end

  assign io_req.req_ready = w_ready;

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= StIdle;
      r_rr_ptr       <= '0;
      r_bit_cnt      <= '0;
      r_gap_cnt      <= '0;
      r_ser_load     <= 1'b0;
      r_ser_data     <= '0;
      r_frame_active <= 1'b0;
      r_frame_ch     <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_ser_data     <= w_gnt_data;
            r_ser_load     <= 1'b1;
            r_frame_ch     <= w_gnt_idx;
            r_rr_ptr       <= w_next_ptr;
            r_frame_active <= 1'b1;
            r_state        <= StLoad;
          end
        end

        // The serializer samples the word at the end of this cycle.
        StLoad: begin
          r_ser_load <= 1'b0;
          r_bit_cnt  <= CNT_W'(DATA_W - 1);
          r_state    <= StShift;
        end

        // DATA_W cycles, one per bit on serial_out.
        StShift: begin
          if (r_bit_cnt == '0) begin
            r_frame_done   <= 1'b1;
            r_frame_active <= 1'b0;
            if (GAP_CYCLES > 0) begin
              r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
              r_state   <= StGap;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt - CNT_W'(1);
          end
        end

        StGap: begin
          if (r_gap_cnt == '0) begin
            r_state <= StIdle;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_ser_load     = r_ser_load;
  assign o_ser_data     = r_ser_data;
  assign o_frame_active = r_frame_active;
  assign o_frame_ch     = r_frame_ch;
  assign o_frame_done   = r_frame_done;

endmodule

// File: tb/tb_serializer_arbiter.sv
// Directed bench for serializer_arbiter. Two instances share clk/reset: the
// default configuration (GAP_CYCLES = 0) and a GAP_CYCLES = 3 variant. A small
// MSB-first serializer model follows the default instance so the serial bit
// stream can be checked. Outputs are sampled 1 time unit after the falling edge.
module tb_serializer_arbiter;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 10;

  logic clk;
  logic reset;
  logic enable;
  logic g_enable;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [DATA_W-1:0] dat [NUM_CH];

  // Default instance
  serializer_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) req_if ();
  logic              ser_load;
  logic [DATA_W-1:0] ser_data;
  logic              frame_active;
  logic [1:0]        frame_ch;
  logic              frame_done;

  serializer_arbiter #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .GAP_CYCLES (0)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .i_enable       (enable),
    .io_req         (req_if.slave),
    .o_ser_load     (ser_load),
    .o_ser_data     (ser_data),
    .o_frame_active (frame_active),
    .o_frame_ch     (frame_ch),
    .o_frame_done   (frame_done)
  );

  // GAP_CYCLES = 3 instance
  serializer_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) g_if ();
  logic              g_ser_load;
  logic [DATA_W-1:0] g_ser_data;
  logic              g_frame_active;
  logic [1:0]        g_frame_ch;
  logic              g_frame_done;

  serializer_arbiter #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .GAP_CYCLES (3)
  ) u_dut_gap (
    .clk            (clk),
    .reset          (reset),
    .i_enable       (g_enable),
    .io_req         (g_if.slave),
    .o_ser_load     (g_ser_load),
    .o_ser_data     (g_ser_data),
    .o_frame_active (g_frame_active),
    .o_frame_ch     (g_frame_ch),
    .o_frame_done   (g_frame_done)
  );

  // Serializer model: load on ser_load, shift DATA_W-1 times, then hold bit 0.
  logic [DATA_W-1:0] ser_shreg;
  logic [3:0]        ser_cnt;
  logic              ser_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ser_shreg <= '0;
      ser_cnt   <= '0;
    end else if (ser_load) begin
      ser_shreg <= ser_data;
      ser_cnt   <= 4'(DATA_W - 1);
    end else if (ser_cnt != 4'd0) begin
      ser_shreg <= {ser_shreg[DATA_W-2:0], 1'b0};
      ser_cnt   <= ser_cnt - 4'd1;
    end
  end

  assign ser_out = ser_shreg[DATA_W-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a grant on the default instance, starting with the
  // current cycle; checks the one-hot grant, grant spacing and the LOAD cycle.
  task automatic expect_grant(input string tag, input int ch, input int budget,
                              input int exp_dt, inout int prev_t);
    int         t;
    logic [3:0] r;
    logic [3:0] one;
    t   = -1;
    r   = '0;
    one = 4'd1 << ch;
    for (int i = 0; i < budget; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      if (|req_if.req_ready) begin
        r = req_if.req_ready;
        t = cyc;
        break;
      end
    end
    check_val({tag, "_rdy"}, 32'(r), 32'(one));
    if (prev_t >= 0) check_val({tag, "_dt"}, t - prev_t, exp_dt);
    prev_t = t;
    @(negedge clk);
    #1;
    check_val({tag, "_load"}, 32'(ser_load), 32'd1);
    check_val({tag, "_ch"}, 32'(frame_ch), ch);
    check_val({tag, "_data"}, 32'(ser_data), 32'(dat[ch]));
  endtask

  initial begin
    int                prev;
    int                cnt;
    int                low;
    int                dt;
    logic [3:0]        r;
    logic [DATA_W-1:0] w;

    dat[0] = 10'h2A5;
    dat[1] = 10'h155;
    dat[2] = 10'h3C3;
    dat[3] = 10'h0F0;

    reset            = 1'b1;
    enable           = 1'b1;
    g_enable         = 1'b0;
    req_if.req_valid = 4'b0010;
    req_if.req_data  = {dat[3], dat[2], dat[1], dat[0]};
    g_if.req_valid   = 4'b0000;
    g_if.req_data    = {dat[3], dat[2], dat[1], dat[0]};

    // Reset state, with a request pending to show req_ready stays low
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_ready", 32'(req_if.req_ready), 32'd0);
    check_val("rst_load", 32'(ser_load), 32'd0);
    check_val("rst_data", 32'(ser_data), 32'd0);
    check_val("rst_active", 32'(frame_active), 32'd0);
    check_val("rst_ch", 32'(frame_ch), 32'd0);
    check_val("rst_done", 32'(frame_done), 32'd0);

    // 1. Single word on ch0
    @(negedge clk);
    reset            = 1'b0;
    req_if.req_valid = 4'b0001;
    #1;
    check_val("t1_ready", 32'(req_if.req_ready), 32'b0001);
    @(negedge clk);
    req_if.req_valid = 4'b0000;
    #1;
    check_val("t1_ready_off", 32'(req_if.req_ready), 32'd0);
    check_val("t1_load", 32'(ser_load), 32'd1);
    check_val("t1_data", 32'(ser_data), 32'h2A5);
    check_val("t1_ch", 32'(frame_ch), 32'd0);
    check_val("t1_active", 32'(frame_active), 32'd1);
    w = 10'b1010100101;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      check_val("t1_bit", 32'(ser_out), 32'(w[9-k]));
      check_val("t1_done_early", 32'(frame_done), 32'd0);
      if (k == 0) check_val("t1_load_off", 32'(ser_load), 32'd0);
    end
    @(negedge clk);
    #1;
    check_val("t1_done", 32'(frame_done), 32'd1);
    check_val("t1_lsb_hold", 32'(ser_out), 32'd1);
    check_val("t1_active_off", 32'(frame_active), 32'd0);
    @(negedge clk);
    #1;
    check_val("t1_done_pulse", 32'(frame_done), 32'd0);
    check_val("t1_data_hold", 32'(ser_data), 32'h2A5);

    // 2. All four valid after a reset: 0,1,2,3,0 every 12 cycles
    @(negedge clk);
    reset            = 1'b1;
    req_if.req_valid = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    #1;
    prev = -1;
    expect_grant("t2_g0", 0, 15, 12, prev);
    expect_grant("t2_g1", 1, 15, 12, prev);
    expect_grant("t2_g2", 2, 15, 12, prev);
    expect_grant("t2_g3", 3, 15, 12, prev);
    expect_grant("t2_g4", 0, 15, 12, prev);

    // 3. Only ch2 and ch0 valid, rr_ptr = 1: 2, 0 (wrap), 2
    req_if.req_valid = 4'b0101;
    expect_grant("t3_g0", 2, 15, 12, prev);
    expect_grant("t3_g1", 0, 15, 12, prev);
    expect_grant("t3_g2", 2, 15, 12, prev);

    // 5. Drop enable in the 5th SHIFT cycle of that frame
    repeat (5) @(negedge clk);
    enable           = 1'b0;
    req_if.req_valid = 4'b0100;
    repeat (6) @(negedge clk);
    #1;
    check_val("t5_done", 32'(frame_done), 32'd1);
    check_val("t5_active_off", 32'(frame_active), 32'd0);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      #1;
      if (|req_if.req_ready || ser_load) cnt++;
    end
    check_val("t5_no_grant", cnt, 0);
    @(negedge clk);
    enable = 1'b1;
    #1;
    prev = -1;
    expect_grant("t5_resume", 2, 2, 0, prev);

    // 6. Reset in the 3rd SHIFT cycle; ch1 and ch3 pending afterwards
    repeat (3) @(negedge clk);
    reset            = 1'b1;
    req_if.req_valid = 4'b1010;
    #1;
    check_val("t6_ready", 32'(req_if.req_ready), 32'd0);
    check_val("t6_load", 32'(ser_load), 32'd0);
    check_val("t6_data", 32'(ser_data), 32'd0);
    check_val("t6_active", 32'(frame_active), 32'd0);
    check_val("t6_ch", 32'(frame_ch), 32'd0);
    check_val("t6_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    prev = -1;
    expect_grant("t6_after", 1, 2, 0, prev);
    enable = 1'b0;

    // 4. GAP_CYCLES = 3, ch0 and ch1 valid: grants 15 cycles apart
    @(negedge clk);
    g_enable       = 1'b1;
    g_if.req_valid = 4'b0011;
    #1;
    check_val("t4_rdy0", 32'(g_if.req_ready), 32'b0001);
    low = 0;
    dt  = -1;
    r   = '0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      #1;
      if (j == 12) check_val("t4_done", 32'(g_frame_done), 32'd1);
      if (!g_frame_active) low++;
      if (|g_if.req_ready) begin
        dt = j;
        r  = g_if.req_ready;
        break;
      end
    end
    check_val("t4_rdy1", 32'(r), 32'b0010);
    check_val("t4_dt", dt, 15);
    check_val("t4_low", low, 4);
    g_enable = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
